reaction_timer_ctrl: RTL and testbench



---
 rtl/reaction_pkg.sv | 20 ++
 rtl/bcd_counter3.sv | 47 ++++
 rtl/reaction_timer_ctrl.sv | 120 ++++++++++++
 tb/tb_reaction_timer_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer control stage.
package reaction_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT   = 2'b01,
    TIMING = 2'b10,
    DONE   = 2'b11
  } state_t;

  localparam logic [11:0] BCD_OVF   = 12'hFFF;
  localparam logic [11:0] BCD_MAX   = 12'h999;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fibonacci LFSR, taps 16/14/13/11, shifting toward the MSB.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

endpackage

// File: rtl/bcd_counter3.sv
// Three-digit ripple BCD counter that saturates to the all-F sentinel.
module bcd_counter3
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        sat,
  input  logic        inc,
  output logic [11:0] bcd,
  output logic        ovf
);

  logic [11:0] bcd_inc;

  assign ovf = (bcd == BCD_OVF);

  // Decimal ripple: a digit at 9 wraps to 0 and carries into the next digit.
  always_comb begin
    bcd_inc = bcd;
    if (bcd[3:0] != 4'd9) begin
      bcd_inc[3:0] = bcd[3:0] + 4'd1;
    end else begin
      bcd_inc[3:0] = 4'd0;
      if (bcd[7:4] != 4'd9) begin
        bcd_inc[7:4] = bcd[7:4] + 4'd1;
      end else begin
        bcd_inc[7:4]  = 4'd0;
        bcd_inc[11:8] = bcd[11:8] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcd <= 12'h000;
    end else if (clr) begin
      bcd <= 12'h000;
    end else if (sat) begin
      bcd <= BCD_OVF;
    end else if (inc) begin
      if (ovf || bcd == BCD_MAX) bcd <= BCD_OVF;
      else                       bcd <= bcd_inc;
    end
  end

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer control: game FSM, 1 ms prescaler, random-delay LFSR and
// the BCD millisecond count feeding the display stage.
module reaction_timer_ctrl
  import reaction_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int TIC_DIV     = CLK_HZ / 1000,
  parameter int MIN_WAIT_MS = 2000,
  parameter int RAND_BITS   = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clr,
  output logic        tic_ms,
  output logic [1:0]  state_system,
  output logic [11:0] bcd,
  output logic        stim_led
);

  localparam int PRE_W  = (TIC_DIV > 1) ? $clog2(TIC_DIV) : 1;
  localparam int WAIT_W = $clog2(MIN_WAIT_MS + (1 << RAND_BITS)) + 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TIC_DIV - 1);

  state_t            state;
  logic [PRE_W-1:0]  pre_cnt;
  logic [15:0]       lfsr;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_ms;
  logic [WAIT_W-1:0] wait_next;
  logic              go_timing;
  logic              cnt_clr;
  logic              cnt_sat;
  logic              cnt_inc;
  logic              bcd_ovf;

  assign state_system = state;
  assign wait_next    = wait_cnt + WAIT_W'(1);

  // Event decode with priority clr > stop > start > tic_ms.
  assign go_timing = (state == WAIT) && !clr && !stop && tic_ms && (wait_next == wait_ms);
  assign cnt_clr   = clr || ((state == IDLE) && start) || go_timing;
  assign cnt_sat   = !clr && (state == WAIT) && stop;
  assign cnt_inc   = !clr && !stop && (state == TIMING) && tic_ms && !bcd_ovf;

  // Restarting the prescaler on TIMING entry makes every reaction start on a
  // full millisecond boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt <= '0;
      tic_ms  <= 1'b0;
    end else begin
      tic_ms <= (pre_cnt == PRE_LAST);
      if (go_timing || pre_cnt == PRE_LAST) pre_cnt <= '0;
      else                                  pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= LFSR_SEED;
    else      lfsr <= lfsr_next(lfsr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      wait_ms  <= '0;
      stim_led <= 1'b0;
    end else if (clr) begin
      state    <= IDLE;
      wait_cnt <= '0;
      stim_led <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= WAIT;
            wait_cnt <= '0;
            wait_ms  <= WAIT_W'(MIN_WAIT_MS) + WAIT_W'(lfsr[RAND_BITS-1:0]);
          end
        end
        WAIT: begin
          if (stop) begin
            state <= DONE;
          end else if (go_timing) begin
            state    <= TIMING;
            stim_led <= 1'b1;
          end else if (tic_ms) begin
            wait_cnt <= wait_next;
          end
        end
        TIMING: begin
          if (stop || (tic_ms && bcd == BCD_MAX)) begin
            state    <= DONE;
            stim_led <= 1'b0;
          end
        end
        DONE: begin
        end
        default: begin
          state    <= IDLE;
          stim_led <= 1'b0;
        end
      endcase
    end
  end

  bcd_counter3 u_bcd (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .sat (cnt_sat),
    .inc (cnt_inc),
    .bcd (bcd),
    .ovf (bcd_ovf)
  );

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed self-checking bench for reaction_timer_ctrl with a 10-clk millisecond.
module tb_reaction_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clr = 1'b0;
  logic        tic_ms;
  logic [1:0]  state_system;
  logic [11:0] bcd;
  logic        stim_led;

  int errors = 0;
  int checks = 0;
  int exp_wait = 0;
  logic [15:0] m_lfsr;

  reaction_timer_ctrl #(
    .CLK_HZ      (10_000),
    .TIC_DIV     (10),
    .MIN_WAIT_MS (5),
    .RAND_BITS   (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .clr          (clr),
    .tic_ms       (tic_ms),
    .state_system (state_system),
    .bcd          (bcd),
    .stim_led     (stim_led)
  );

  always #5 clk = ~clk;

  // Reference LFSR so the exact random delay chosen at start is known.
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= 16'hACE1;
    else      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic chk_state(input string name, input logic [1:0] exp);
    checks++;
    if (state_system !== exp) begin
      errors++;
      $display("[TB] FAIL %s: state got %b expected %b", name, state_system, exp);
    end
  endtask

  task automatic chk_bcd(input string name, input logic [11:0] exp);
    checks++;
    if (bcd !== exp) begin
      errors++;
      $display("[TB] FAIL %s: bcd got %h expected %h", name, bcd, exp);
    end
  endtask

  task automatic chk_led(input string name, input logic exp);
    checks++;
    if (stim_led !== exp) begin
      errors++;
      $display("[TB] FAIL %s: stim_led got %b expected %b", name, stim_led, exp);
    end
  endtask

  // Stops at a negedge where tic_ms is high (the current cycle counts).
  task automatic wait_tic();
    int n = 0;
    while (tic_ms !== 1'b1 && n < 25) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tic_ms !== 1'b1) begin
      errors++;
      $display("[TB] FAIL tic_timeout: tic_ms got %b expected 1 within 25 clks", tic_ms);
    end
  endtask

  task automatic consume_tics(input int count);
    for (int i = 0; i < count; i++) begin
      wait_tic();
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    exp_wait = 5 + int'(m_lfsr[1:0]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic to_timing();
    int n = 0;
    pulse_clr();
    pulse_start();
    while (state_system == 2'b01 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_state("to_timing", 2'b10);
  endtask

  task automatic test_reset();
    int n;
    @(negedge clk);
    chk_state("reset_state", 2'b00);
    chk_bcd("reset_bcd", 12'h000);
    chk_led("reset_led", 1'b0);
    rst = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tic_ms !== 1'b1 && n < 40);
    checks++;
    if (n != 10) begin
      errors++;
      $display("[TB] FAIL first_tic: clks got %0d expected 10", n);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tic_ms !== 1'b1 && n < 40);
    checks++;
    if (n != 10) begin
      errors++;
      $display("[TB] FAIL tic_period: clks got %0d expected 10", n);
    end
  endtask

  task automatic test_reaction();
    int n;
    logic bad;
    logic [11:0] bad_bcd;
    @(negedge clk);
    pulse_start();
    chk_state("start_wait", 2'b01);
    chk_led("wait_led", 1'b0);
    n = 0;
    while (state_system == 2'b01 && n < 20) begin
      wait_tic();
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != exp_wait) begin
      errors++;
      $display("[TB] FAIL wait_tics: tics got %0d expected %0d", n, exp_wait);
    end
    chk_state("timing_entry", 2'b10);
    chk_led("timing_led", 1'b1);
    chk_bcd("timing_bcd", 12'h000);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tic_ms !== 1'b1 && n < 40);
    checks++;
    if (n != 10) begin
      errors++;
      $display("[TB] FAIL timing_first_tic: clks got %0d expected 10", n);
    end
    @(negedge clk);
    consume_tics(36);
    chk_bcd("count_37", 12'h037);
    pulse_stop();
    chk_state("stop_done", 2'b11);
    chk_bcd("stop_bcd", 12'h037);
    chk_led("done_led", 1'b0);
    bad = 1'b0;
    bad_bcd = bcd;
    repeat (100) begin
      @(negedge clk);
      if (state_system !== 2'b11 || bcd !== 12'h037) begin
        bad = 1'b1;
        bad_bcd = bcd;
      end
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_hold: bcd got %h expected 037 held", bad_bcd);
    end
  endtask

  task automatic test_cheat();
    pulse_clr();
    chk_state("clr_state", 2'b00);
    chk_bcd("clr_bcd", 12'h000);
    pulse_start();
    repeat (2) @(negedge clk);
    pulse_stop();
    chk_state("cheat_state", 2'b11);
    chk_bcd("cheat_bcd", 12'hFFF);
    chk_led("cheat_led", 1'b0);
    pulse_start();
    pulse_stop();
    repeat (20) @(negedge clk);
    chk_state("cheat_ignore_state", 2'b11);
    chk_bcd("cheat_ignore_bcd", 12'hFFF);
  endtask

  task automatic test_timeout();
    to_timing();
    consume_tics(9);
    chk_bcd("bcd_009", 12'h009);
    consume_tics(1);
    chk_bcd("bcd_010", 12'h010);
    consume_tics(89);
    chk_bcd("bcd_099", 12'h099);
    consume_tics(1);
    chk_bcd("bcd_100", 12'h100);
    consume_tics(899);
    chk_bcd("bcd_999", 12'h999);
    chk_state("state_at_999", 2'b10);
    consume_tics(1);
    chk_bcd("timeout_bcd", 12'hFFF);
    chk_state("timeout_state", 2'b11);
    chk_led("timeout_led", 1'b0);
  endtask

  task automatic test_collisions();
    to_timing();
    consume_tics(42);
    chk_bcd("pre_collide", 12'h042);
    wait_tic();
    pulse_stop();
    chk_bcd("stop_tic_bcd", 12'h042);
    chk_state("stop_tic_state", 2'b11);
    to_timing();
    consume_tics(3);
    clr = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    stop = 1'b0;
    chk_state("clr_stop_state", 2'b00);
    chk_bcd("clr_stop_bcd", 12'h000);
    chk_led("clr_stop_led", 1'b0);
  endtask

  task automatic test_async_reset();
    int n;
    to_timing();
    consume_tics(123);
    chk_bcd("pre_reset_bcd", 12'h123);
    #2 rst = 1'b0;
    #1;
    chk_state("async_state", 2'b00);
    chk_bcd("async_bcd", 12'h000);
    chk_led("async_led", 1'b0);
    checks++;
    if (tic_ms !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_tic: tic_ms got %b expected 0", tic_ms);
    end
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tic_ms !== 1'b1 && n < 40);
    checks++;
    if (n != 10) begin
      errors++;
      $display("[TB] FAIL post_reset_tic: clks got %0d expected 10", n);
    end
    chk_state("post_reset_state", 2'b00);
  endtask

  initial begin
    test_reset();
    test_reaction();
    test_cheat();
    test_timeout();
    test_collisions();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
